// File: rtl/apb_pkg.sv
// Shared APB completer types and constants.
package apb_pkg;

    typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_t;

    localparam int unsigned APB_WORD_BYTES = 4;
    localparam int unsigned APB_MAX_WAIT   = 15;

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between the bridge (master) and the register bank (slave).
interface apb_slave_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/apb_regbank.sv
// Word register storage: one write port, one asynchronous read port.
// Register 0 is a read-only ID constant.
module apb_regbank #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hA0B0_0001,
    localparam int unsigned         IdxW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IdxW-1:0]       idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] rd_vec [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0) begin : g_id
            assign rd_vec[i] = ID_VALUE;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    reg_q <= '0;
                end else if (we_i && (idx_i == IdxW'(i))) begin
                    reg_q <= wdata_i;
                end
            end

            assign rd_vec[i] = reg_q;
        end
    end

    assign rdata_o = rd_vec[idx_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer: setup-phase capture, wait-state counter, error decode and
// response muxing in front of the word register bank.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    apb_slave_regbank_if.slave  apb
);

    localparam int unsigned           IdxW      = $clog2(NUM_REGS);
    localparam int unsigned           CntW      = $clog2(APB_MAX_WAIT + 1);
    localparam logic [ADDR_WIDTH-1:0] AddrLimit = ADDR_WIDTH'(APB_WORD_BYTES * NUM_REGS);

    apb_state_t            state_q;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  setup;
    logic                  pready;
    logic                  err_d;
    logic                  bank_we;
    logic [IdxW-1:0]       paddr_idx;
    logic [IdxW-1:0]       bank_idx;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign setup     = apb.PSEL && !apb.PENABLE;
    assign pready    = (state_q == APB_ACCESS) && apb.PSEL && apb.PENABLE && (cnt_q == '0);
    assign err_d     = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR >= AddrLimit);
    assign paddr_idx = apb.PADDR[IdxW+1:2];
    // Setup and completion never coincide, so one bank port serves both.
    assign bank_idx  = pready ? idx_q : paddr_idx;
    assign bank_we   = pready && write_q && !err_q;

    apb_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regbank (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (bank_we),
        .idx_i   (bank_idx),
        .wdata_i (wdata_q),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= APB_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (setup) begin
            state_q <= APB_ACCESS;
            cnt_q   <= CntW'(WAIT_STATES);
            idx_q   <= paddr_idx;
            write_q <= apb.PWRITE;
            err_q   <= err_d;
            wdata_q <= apb.PWDATA;
            rdata_q <= err_d ? '0 : bank_rdata;
        end else if (state_q == APB_ACCESS) begin
            // PSEL dropped mid-access aborts without a write.
            if (!apb.PSEL || (cnt_q == '0)) begin
                state_q <= APB_IDLE;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign apb.PREADY  = pready;
    assign apb.PRDATA  = (pready && !write_q) ? rdata_q : '0;
    assign apb.PSLVERR = pready && err_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized bench for two register-bank completers (0 and 2 wait states)
// against a word-array model of the bank.
module tb_apb_slave_regbank;

    localparam int unsigned NR  = 16;
    localparam logic [31:0] ID  = 32'hA0B0_0001;
    localparam int          WS0 = 0;
    localparam int          WS1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    apb_slave_regbank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(WS0), .ID_VALUE(ID)
    ) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus0)
    );

    apb_slave_regbank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(WS1), .ID_VALUE(ID)
    ) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus1)
    );

    logic        act_rdy [2];
    logic [31:0] act_rd  [2];
    logic        act_er  [2];
    assign act_rdy[0] = bus0.PREADY;
    assign act_rd[0]  = bus0.PRDATA;
    assign act_er[0]  = bus0.PSLVERR;
    assign act_rdy[1] = bus1.PREADY;
    assign act_rd[1]  = bus1.PRDATA;
    assign act_er[1]  = bus1.PSLVERR;

    // Behavioural model: register contents per DUT plus expected outputs.
    logic [31:0] mem [2][NR];
    logic        exp_rdy [2];
    logic [31:0] exp_rd  [2];
    logic        exp_er  [2];
    logic        exp_wr  [2];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %h, want %h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("PREADY", d, 32'(act_rdy[d]), 32'(exp_rdy[d]));
            check("PSLVERR", d, 32'(act_er[d]), 32'(exp_er[d]));
            if (!(exp_rdy[d] && exp_wr[d])) check("PRDATA", d, act_rd[d], exp_rd[d]);
        end
    end

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * NR));
    endfunction

    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
        if (is_err(a)) return 32'h0;
        if (a[5:2] == 4'd0) return ID;
        return mem[d][a[5:2]];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(NR); i++) mem[d][i] = 32'h0;
    endtask

    // One bus cycle on DUT d; the other bus is held idle. Expectations default to 0.
    task automatic drive(input int d, input logic sel, input logic en, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if (d == 0) begin
            bus0.PSEL = sel; bus0.PENABLE = en; bus0.PADDR = a; bus0.PWRITE = wr;
            bus0.PWDATA = wd; bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0;
        end else begin
            bus1.PSEL = sel; bus1.PENABLE = en; bus1.PADDR = a; bus1.PWRITE = wr;
            bus1.PWDATA = wd; bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = 1'b0; exp_rd[i] = 32'h0; exp_er[i] = 1'b0; exp_wr[i] = 1'b0;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, $urandom, 1'b0, $urandom);
    endtask

    // Full transfer; abort_after>=0 drops PSEL after that many PENABLE cycles.
    task automatic xfer(input int d, input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input int abort_after,
                        output logic [31:0] got_rd, output logic got_err, output int lat);
        logic        e;
        logic [31:0] rv;
        logic        done;
        int          ws;
        int          k;
        e = is_err(a);
        rv = model_rd(d, a);
        ws = (d == 0) ? WS0 : WS1;
        k = 0;
        done = 1'b0;
        got_rd = 32'h0;
        got_err = 1'b0;
        lat = -1;
        drive(d, 1'b1, 1'b0, a, wr, wd);
        forever begin
            if (abort_after >= 0 && k == abort_after) begin
                drive(d, 1'b0, 1'b0, a, wr, wd);
                break;
            end
            // Address and data are scrambled during access; the setup capture must hold.
            drive(d, 1'b1, 1'b1, $urandom, wr, $urandom);
            exp_rdy[d] = (k == ws);
            exp_wr[d]  = wr;
            exp_er[d]  = (k == ws) && e;
            exp_rd[d]  = ((k == ws) && !wr) ? rv : 32'h0;
            @(negedge clk);
            if (act_rdy[d]) begin
                got_rd = act_rd[d]; got_err = act_er[d]; lat = k; done = 1'b1;
                break;
            end
            k++;
            if (k > 20) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout dut%0d: got no PREADY after %0d cycles, want 1", d, k);
                break;
            end
        end
        if (done && wr && !e && a[5:2] != 4'd0) mem[d][a[5:2]] = wd;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PADDR = '0; bus0.PWRITE = 1'b0;
        bus0.PWDATA = '0;
        bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0; bus1.PADDR = '0; bus1.PWRITE = 1'b0;
        bus1.PWDATA = '0;
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = 1'b0; exp_rd[i] = 32'h0; exp_er[i] = 1'b0; exp_wr[i] = 1'b0;
        end
        clear_model();
        repeat (3) idle();
        rst_n = 1'b1;
        idle();

        // Reset contents and zero-wait write/read.
        xfer(0, 32'h04, 1'b0, 32'h0, -1, rd, er, lat);
        check("rst_reg1", 0, rd, 32'h0);
        xfer(0, 32'h04, 1'b1, 32'h1234_5678, -1, rd, er, lat);
        check("t1_wr_lat", 0, 32'(lat), 32'd0);
        check("t1_wr_err", 0, 32'(er), 32'd0);
        xfer(0, 32'h04, 1'b0, 32'h0, -1, rd, er, lat);
        check("t1_rd_lat", 0, 32'(lat), 32'd0);
        check("t1_rd", 0, rd, 32'h1234_5678);
        idle();

        // Two wait states.
        xfer(1, 32'h08, 1'b0, 32'h0, -1, rd, er, lat);
        check("t2_lat", 1, 32'(lat), 32'd2);
        check("t2_rd", 1, rd, 32'h0);
        idle();

        // ID register ignores writes without error.
        xfer(0, 32'h00, 1'b1, 32'hFFFF_FFFF, -1, rd, er, lat);
        check("t3_wr_err", 0, 32'(er), 32'd0);
        xfer(0, 32'h00, 1'b0, 32'h0, -1, rd, er, lat);
        check("t3_rd", 0, rd, 32'hA0B0_0001);

        // Misaligned and out-of-range writes.
        xfer(0, 32'h41, 1'b1, 32'hDEAD_0041, -1, rd, er, lat);
        check("t4_mis_err", 0, 32'(er), 32'd1);
        xfer(0, 32'h40, 1'b1, 32'hDEAD_0040, -1, rd, er, lat);
        check("t4_oor_err", 0, 32'(er), 32'd1);
        for (int i = 0; i < int'(NR); i++) xfer(0, 32'(4 * i), 1'b0, 32'h0, -1, rd, er, lat);
        xfer(0, 32'h04, 1'b0, 32'h0, -1, rd, er, lat);
        check("t4_reg1", 0, rd, 32'h1234_5678);

        // Back-to-back write then read.
        xfer(0, 32'h0C, 1'b1, 32'h0000_CAFE, -1, rd, er, lat);
        xfer(0, 32'h0C, 1'b0, 32'h0, -1, rd, er, lat);
        check("t5_rd", 0, rd, 32'h0000_CAFE);
        idle();

        // Reset in the middle of a waited write.
        drive(1, 1'b1, 1'b0, 32'h10, 1'b1, 32'hBEEF_0010);
        drive(1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hBEEF_0010);
        drive(1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hBEEF_0010);
        #2 rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        check("t6_rdy_in_rst", 1, 32'(act_rdy[1]), 32'd0);
        idle();
        rst_n = 1'b1;
        idle();
        xfer(1, 32'h10, 1'b0, 32'h0, -1, rd, er, lat);
        check("t6_rd", 1, rd, 32'h0);

        // Randomized traffic, including protocol violations.
        for (int n = 0; n < 300; n++) begin
            int          d;
            int          op;
            int          kind;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       a = {26'h0, 4'($urandom), 2'b00};
            else if (kind == 7) a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
            else if (kind == 8) a = 32'h40 + {20'h0, 10'($urandom), 2'b00};
            else                a = $urandom;
            op = int'($urandom_range(0, 19));
            if (op == 0) begin
                drive(d, 1'b1, 1'b1, a, 1'b1, $urandom);
            end else if (op == 1) begin
                xfer(d, a, 1'($urandom), $urandom, int'($urandom_range(0, 1)), rd, er, lat);
            end else begin
                xfer(d, a, 1'($urandom), $urandom, -1, rd, er, lat);
            end
            if ($urandom_range(0, 1) == 0 || op == 0) idle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
